switch_deadtime_gen: RTL and testbench

SWITCH_DEADTIME_GEN -- requirements
Module: switch_deadtime_gen

---
 rtl/switch_deadtime_gen.sv | 149 ++++++++++++++
 tb/tb_switch_deadtime_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_deadtime_gen.sv
// Complementary switch driver with programmable dead time.
// A 5-state Moore FSM turns the 50% pwm_in clock into two non-overlapping
// phase drives (sw_p / sw_n), separated by DEAD_CYCLES clocks with both low.
// All outputs are flops loaded from the decoded next state.
// Optional build macro: SWITCH_DT_SYNC_EN -- adds a 2-flop synchronizer on
// pwm_in for an asynchronous source (2 extra cycles of latency).
module switch_deadtime_gen #(
  parameter int DEAD_CYCLES = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic pwm_in,
  output logic sw_p,
  output logic sw_n,
  output logic dead,
  output logic fault
);

  typedef enum logic [2:0] {
    OFF  = 3'd0,
    DT_P = 3'd1,
    P_ON = 3'd2,
    DT_N = 3'd3,
    N_ON = 3'd4
  } state_t;

  // Counter starts at DEAD_CYCLES-1 so the dead interval spans DEAD_CYCLES edges.
  localparam logic [7:0] RELOAD = 8'(DEAD_CYCLES - 1);

  logic pwm_s;

`ifdef SWITCH_DT_SYNC_EN
  logic [1:0] sync_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First synchronizer stage captures the raw input.
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= 1'b0;
          else     sync_reg[gi] <= pwm_in;
        end
      end else begin : g_rest
        // Later stages shift the previous stage along.
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= 1'b0;
          else     sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign pwm_s = sync_reg[1];
`else
  assign pwm_s = pwm_in;
`endif

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       fault_reg, fault_next;
  logic       sw_p_reg, sw_n_reg, dead_reg;

  // Next-state, counter and fault logic; en low overrides everything.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    fault_next = fault_reg;
    if (!en) begin
      state_next = OFF;
      cnt_next   = 8'd0;
      fault_next = 1'b0;
    end else begin
      case (state_reg)
        OFF: begin
          state_next = pwm_s ? DT_P : DT_N;
          cnt_next   = RELOAD;
        end
        DT_P: begin
          // A reversal inside the dead window restarts the opposite dead
          // time; it takes precedence over completion so no wrong pulse escapes.
          if (!pwm_s) begin
            state_next = DT_N;
            cnt_next   = RELOAD;
            fault_next = 1'b1;
          end else if (cnt_reg == 8'd0) begin
            state_next = P_ON;
          end else begin
            cnt_next = cnt_reg - 8'd1;
          end
        end
        P_ON: begin
          if (!pwm_s) begin
            state_next = DT_N;
            cnt_next   = RELOAD;
          end
        end
        DT_N: begin
          if (pwm_s) begin
            state_next = DT_P;
            cnt_next   = RELOAD;
            fault_next = 1'b1;
          end else if (cnt_reg == 8'd0) begin
            state_next = N_ON;
          end else begin
            cnt_next = cnt_reg - 8'd1;
          end
        end
        N_ON: begin
          if (pwm_s) begin
            state_next = DT_P;
            cnt_next   = RELOAD;
          end
        end
        default: begin
          state_next = OFF;
          cnt_next   = 8'd0;
        end
      endcase
    end
  end

  // State, counter, fault and output registers; outputs decode the next state
  // so a phase drops on the same edge its pwm change is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= OFF;
      cnt_reg   <= 8'd0;
      fault_reg <= 1'b0;
      sw_p_reg  <= 1'b0;
      sw_n_reg  <= 1'b0;
      dead_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      fault_reg <= fault_next;
      sw_p_reg  <= (state_next == P_ON);
      sw_n_reg  <= (state_next == N_ON);
      dead_reg  <= (state_next == DT_P) || (state_next == DT_N);
    end
  end

  assign sw_p  = sw_p_reg;
  assign sw_n  = sw_n_reg;
  assign dead  = dead_reg;
  assign fault = fault_reg;

endmodule

// File: tb/tb_switch_deadtime_gen.sv
// Self-checking bench for switch_deadtime_gen: a timestamp-based model of the
// dead-time rules checked every cycle, directed scenarios with literal
// expectations, then a randomized soak.
module tb_switch_deadtime_gen;

  localparam int D = 100;
`ifdef SWITCH_DT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic pwm_in = 1'b0;
  logic sw_p, sw_n, dead, fault;

  int checks = 0;
  int errors = 0;

  switch_deadtime_gen #(.DEAD_CYCLES(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .pwm_in(pwm_in),
    .sw_p  (sw_p),
    .sw_n  (sw_n),
    .dead  (dead),
    .fault (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the drive is "active" towards a target phase; it has
  // been in that target for m_since edges. Output is live once m_since >= D.
  bit m_valid = 1'b0;
  bit m_active = 1'b0;
  bit m_target = 1'b0;
  bit m_fault = 1'b0;
  int m_since = 0;
  bit h1 = 1'b0, h2 = 1'b0;
  bit ps;

  initial begin
    forever begin
      @(posedge clk);
      ps = (LAT == 2) ? h2 : pwm_in;
      if (rst) begin
        m_active = 1'b0;
        m_fault  = 1'b0;
        m_since  = 0;
        m_valid  = 1'b1;
      end else if (!en) begin
        m_active = 1'b0;
        m_fault  = 1'b0;
      end else if (!m_active) begin
        m_active = 1'b1;
        m_target = ps;
        m_since  = 0;
      end else if (ps != m_target) begin
        if (m_since < D) m_fault = 1'b1;
        m_target = ps;
        m_since  = 0;
      end else if (m_since < 100000) begin
        m_since++;
      end
      if (rst) begin
        h1 = 1'b0;
        h2 = 1'b0;
      end else begin
        h2 = h1;
        h1 = pwm_in;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("sw_p_model", int'(sw_p), int'(m_active && m_target && (m_since >= D)));
        chk("sw_n_model", int'(sw_n), int'(m_active && !m_target && (m_since >= D)));
        chk("dead_model", int'(dead), int'(m_active && (m_since < D)));
        chk("fault_model", int'(fault), int'(m_fault));
        chk("no_overlap", int'(sw_p && sw_n), 0);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int first_n, first_p, cp, cn;

  initial begin
    // Reset
    tick(3);
    chk("rst_sw_p", int'(sw_p), 0);
    chk("rst_sw_n", int'(sw_n), 0);
    chk("rst_dead", int'(dead), 0);
    chk("rst_fault", int'(fault), 0);

    // Settle into N phase
    rst = 1'b0; en = 1'b1; pwm_in = 1'b0;
    tick(150);
    chk("settle_sw_n", int'(sw_n), 1);
    chk("settle_fault", int'(fault), 0);

    // pwm rising edge: sw_n drop latency and sw_p rise latency
    pwm_in = 1'b1;
    first_n = -1; first_p = -1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (first_n < 0 && !sw_n) first_n = k - 1;
      if (first_p < 0 && sw_p) begin
        first_p = k - 1;
        break;
      end
    end
    chk("n_drop_latency", first_n, LAT);
    chk("p_rise_latency", first_p, D + LAT);

    // Scaled period test: 2000-cycle period, each phase high 900 per period
    cp = 0; cn = 0;
    for (int k = 0; k < 4000; k++) begin
      if (k % 1000 == 0) pwm_in = ~pwm_in;
      @(negedge clk);
      if (k >= 2000) begin
        cp += int'(sw_p);
        cn += int'(sw_n);
      end
    end
    chk("period_p_high", cp, 900);
    chk("period_n_high", cn, 900);

    // Short low glitch in P_ON: fault, no sw_n pulse
    tick(200);
    pwm_in = 1'b0;
    cn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      cn += int'(sw_n);
    end
    pwm_in = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      cn += int'(sw_n);
    end
    chk("glitch_no_sw_n", cn, 0);
    chk("glitch_fault", int'(fault), 1);
    chk("glitch_sw_p_back", int'(sw_p), 1);

    // en dropped mid P_ON
    en = 1'b0;
    tick(1);
    chk("en_off_sw_p", int'(sw_p), 0);
    chk("en_off_dead", int'(dead), 0);
    chk("en_off_fault", int'(fault), 0);
    pwm_in = 1'b0;
    tick(4);
    en = 1'b1;
    first_n = -1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (sw_n) begin
        first_n = k - 1;
        break;
      end
    end
    chk("en_on_sw_n_latency", first_n, D);

    // en dropped mid DT_N
    pwm_in = 1'b1;
    tick(150);
    pwm_in = 1'b0;
    tick(LAT + 30);
    chk("mid_dtn_dead", int'(dead), 1);
    en = 1'b0;
    tick(1);
    chk("mid_dtn_off_dead", int'(dead), 0);
    chk("mid_dtn_off_sw_n", int'(sw_n), 0);

    // rst pulse around count 50 of DT_P
    en = 1'b1;
    tick(150);
    pwm_in = 1'b1;
    tick(LAT + 50);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_mid_sw_p", int'(sw_p), 0);
    chk("rst_mid_dead", int'(dead), 0);
    chk("rst_mid_fault", int'(fault), 0);
    cp = 0;
    for (int k = 0; k < D; k++) begin
      @(negedge clk);
      cp += int'(sw_p);
    end
    chk("rst_no_partial_pulse", cp, 0);
    tick(50);
    chk("rst_fresh_sw_p", int'(sw_p), 1);

    // Randomized soak, checked cycle by cycle against the model
    for (int k = 0; k < 20000; k++) begin
      if ($urandom_range(0, 999) < ((k / 5000) % 2 == 0 ? 8 : 30)) pwm_in = ~pwm_in;
      en  = ($urandom_range(0, 1499) != 0);
      rst = ($urandom_range(0, 4999) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
